can_clic_ctrl: RTL and testbench
================================

// Module: can_clic_ctrl
// PURPOSE
//  Sequencing controller around the combinational CLIC priority selector. Latches interrupt
//  sources into pending bits and holds per-source enable/priority/trigger config. Arbitrates
//  the highest-priority eligible source above the current running level and hands it to the
//  core with a req/ack handshake. Keeps a nesting stack of preempted levels, popped on done.
// PARAMETERS
//  N_IRQ   4  number of interrupt sources
//  PRIO_W  2  priority width; 0 = never interrupts
//  DEPTH   4  max nesting depth (stack entries)
// PORTS
//  clk         in   1                    clock, all state on rising edge
//  rst_n       in   1                    asynchronous reset, active low
//  irq_i       in   N_IRQ                raw interrupt source lines
//  cfg_we      in   1                    config write strobe
//  cfg_idx     in   $clog2(N_IRQ)        source index being configured
//  cfg_en      in   1                    enable for cfg_idx
//  cfg_prio    in   PRIO_W               priority for cfg_idx
//  cfg_edge    in   1                    1 = rising-edge triggered, 0 = level
//  irq_req_o   out  1                    interrupt request to core
//  irq_id_o    out  $clog2(N_IRQ)        requested source index
//  irq_prio_o  out  PRIO_W               requested priority
//  irq_ack_i   in   1                    core accepts request (handler entry)
//  irq_done_i  in   1                    core returns from handler
//  level_o     out  PRIO_W               current running priority level
//  nest_o      out  $clog2(DEPTH+1)      current nesting depth
// BEHAVIOUR
//  Reset: all pending/en/prio/edge/prev regs 0; irq_req_o=0, irq_id_o=0, irq_prio_o=0,
//   level_o=0, nest_o=0, FSM=IDLE. Reset mid-handshake abandons request; no ack required.
//  Pending: edge src sets pend on irq_i 0->1 (prev registered), sticky until ack of that src;
//   level src pend = irq_i registered (1 cycle). Config write applies next cycle.
//  Eligible(i) = pend[i] & en[i] & prio[i] > level_o & nest_o < DEPTH.
//  Arbitration: max prio among eligible; tie -> lowest index. No eligible -> no candidate.
//  FSM IDLE: candidate -> REQ next cycle, latch id/prio (IDLE->req latency 1 cycle).
//  FSM REQ: irq_req_o=1, id/prio held stable, no re-arbitration.
//   ack -> push level_o, level_o<=irq_prio_o, nest_o++, clear pend[id] if edge, -> IDLE.
//   latched source no longer eligible (level drop, disabled, reprio) and no ack -> IDLE,
//   req drops next cycle.
//  done (any state, nest_o>0): pop stack into level_o, nest_o--. done at nest_o=0: ignored.
//  ack and done same cycle in REQ: ack processed, done ignored. ack outside REQ: ignored.
//  After ack/pop, re-arbitration restarts from IDLE with the updated level.
//  nest_o=DEPTH: no new request issued until a done pops.
//  Edge event arriving on a src already pending: coalesced, single ack clears it.
// TESTING
//  1 prio {3,0,2,1}, all en, level pulses on 0..3 -> req id=0 prio=3, 1 cycle after pend.
//  2 prio {1,3,3,0}, pend 1,2 -> id=1 (tie lowest index); ack -> level_o=3, nest_o=1.
//  3 running at level 1; src2 prio 2 pends -> req, ack -> nest_o=2; done x2 -> level 1, then 0.
//  4 edge src0 pulse while req on src0 held, ack -> pend cleared; 2nd pulse -> new req.
//  5 level src drops in REQ before ack -> req deasserts next cycle, FSM IDLE, nest_o unchanged.
//  6 DEPTH=4 reached -> higher prio pend gives no req; done -> req issued; rst_n low mid-REQ
//     -> all outputs 0 immediately.

Source files
------------

// File: rtl/can_clic_ctrl_if.sv
// Core-side interrupt handshake: request/id/priority from the controller, ack/done from the core.
interface can_clic_ctrl_if #(
  parameter int N_IRQ  = 4,
  parameter int PRIO_W = 2
);
  localparam int ID_W = $clog2(N_IRQ);

  logic              irq_req_o;
  logic [ID_W-1:0]   irq_id_o;
  logic [PRIO_W-1:0] irq_prio_o;
  logic              irq_ack_i;
  logic              irq_done_i;

  modport master (
    output irq_req_o, irq_id_o, irq_prio_o,
    input  irq_ack_i, irq_done_i
  );

  modport slave (
    input  irq_req_o, irq_id_o, irq_prio_o,
    output irq_ack_i, irq_done_i
  );
endinterface

// File: rtl/can_clic_ctrl.sv
// Interrupt sequencing controller: pending capture, per-source config, priority arbitration,
// req/ack handshake to the core and a stack of preempted levels popped on handler return.
module can_clic_ctrl #(
  parameter int N_IRQ  = 4,
  parameter int PRIO_W = 2,
  parameter int DEPTH  = 4,
  localparam int ID_W   = $clog2(N_IRQ),
  localparam int NEST_W = $clog2(DEPTH + 1),
  localparam int SP_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_IRQ-1:0]    irq_i,
  input  logic                cfg_we,
  input  logic [ID_W-1:0]     cfg_idx,
  input  logic                cfg_en,
  input  logic [PRIO_W-1:0]   cfg_prio,
  input  logic                cfg_edge,
  can_clic_ctrl_if.master     core,
  output logic [PRIO_W-1:0]   level_o,
  output logic [NEST_W-1:0]   nest_o
);

  typedef enum logic {S_IDLE, S_REQ} state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [N_IRQ-1:0]    r_en;
  logic [N_IRQ-1:0]    r_edge;
  logic [N_IRQ-1:0]    r_prev;
  logic [N_IRQ-1:0]    r_pend;
  logic [PRIO_W-1:0]   r_prio [N_IRQ];
  logic [PRIO_W-1:0]   r_stack [DEPTH];
  logic [PRIO_W-1:0]   r_level;
  logic [NEST_W-1:0]   r_nest;
  logic [ID_W-1:0]     r_id;
  logic [PRIO_W-1:0]   r_req_prio;

  logic [N_IRQ-1:0]    w_elig;
  logic                w_cand;
  logic [ID_W-1:0]     w_cand_id;
  logic [PRIO_W-1:0]   w_cand_prio;
  logic                w_latch;
  logic                w_ack;
  logic                w_pop;
  logic                w_room;

  assign w_room = (r_nest < NEST_W'(DEPTH));

  genvar gi;
  generate
    for (gi = 0; gi < N_IRQ; gi++) begin : g_elig
      assign w_elig[gi] = r_pend[gi] & r_en[gi] & (r_prio[gi] > r_level) & w_room;
    end
  endgenerate

  // Strict '>' keeps the lowest index on equal priority.
  always_comb begin
    w_cand      = 1'b0;
    w_cand_id   = '0;
    w_cand_prio = '0;
    for (int i = 0; i < N_IRQ; i++) begin
      if (w_elig[i] && (!w_cand || (r_prio[i] > w_cand_prio))) begin
        w_cand      = 1'b1;
        w_cand_id   = ID_W'(i);
        w_cand_prio = r_prio[i];
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_latch      = 1'b0;
    w_ack        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_cand) begin
          w_state_next = S_REQ;
          w_latch      = 1'b1;
        end
      end
      S_REQ: begin
        if (core.irq_ack_i) begin
          w_ack        = 1'b1;
          w_state_next = S_IDLE;
        end else if (!w_elig[r_id]) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // An ack in the same cycle takes precedence over a return.
  assign w_pop = core.irq_done_i && (r_nest != '0) && !w_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_id       <= '0;
      r_req_prio <= '0;
      r_level    <= '0;
      r_nest     <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_latch) begin
        r_id       <= w_cand_id;
        r_req_prio <= w_cand_prio;
      end
      if (w_ack) begin
        r_level <= r_req_prio;
        r_nest  <= r_nest + 1'b1;
      end else if (w_pop) begin
        r_level <= r_stack[SP_W'(r_nest - 1'b1)];
        r_nest  <= r_nest - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_ack) r_stack[r_nest[SP_W-1:0]] <= r_level;
  end

  // Edge sources stay pending until their own ack; a new edge in the ack cycle is kept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_en   <= '0;
      r_edge <= '0;
      r_prev <= '0;
      r_pend <= '0;
      for (int i = 0; i < N_IRQ; i++) r_prio[i] <= '0;
    end else begin
      r_prev <= irq_i;
      for (int i = 0; i < N_IRQ; i++) begin
        if (r_edge[i])
          r_pend[i] <= (r_pend[i] & ~(w_ack && (r_id == ID_W'(i)))) | (irq_i[i] & ~r_prev[i]);
        else
          r_pend[i] <= irq_i[i];
        if (cfg_we && (cfg_idx == ID_W'(i))) begin
          r_en[i]   <= cfg_en;
          r_prio[i] <= cfg_prio;
          r_edge[i] <= cfg_edge;
        end
      end
    end
  end

  assign core.irq_req_o  = (r_state == S_REQ);
  assign core.irq_id_o   = r_id;
  assign core.irq_prio_o = r_req_prio;
  assign level_o         = r_level;
  assign nest_o          = r_nest;

endmodule

// File: tb/tb_can_clic_ctrl.sv
// Directed bench for can_clic_ctrl: expected requests are queued at stimulus time and
// matched by a monitor on each new request; level/nest/latency checked inline.
module tb_can_clic_ctrl;
  localparam int N_IRQ  = 4;
  localparam int PRIO_W = 3;
  localparam int DEPTH  = 4;

  typedef struct {
    int id;
    int prio;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [3:0]  irq;
  logic        cfg_we;
  logic [1:0]  cfg_idx;
  logic        cfg_en;
  logic [2:0]  cfg_prio;
  logic        cfg_edge;
  logic [2:0]  level;
  logic [2:0]  nest;

  int   errors = 0;
  int   checks = 0;
  exp_t q[$];

  can_clic_ctrl_if #(.N_IRQ(N_IRQ), .PRIO_W(PRIO_W)) bus ();

  can_clic_ctrl #(.N_IRQ(N_IRQ), .PRIO_W(PRIO_W), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .irq_i    (irq),
    .cfg_we   (cfg_we),
    .cfg_idx  (cfg_idx),
    .cfg_en   (cfg_en),
    .cfg_prio (cfg_prio),
    .cfg_edge (cfg_edge),
    .core     (bus),
    .level_o  (level),
    .nest_o   (nest)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic push(input int id, input int prio);
    exp_t e;
    e.id   = id;
    e.prio = prio;
    q.push_back(e);
  endtask

  task automatic cfg(input int idx, input bit en, input int prio, input bit edg);
    cfg_we   = 1'b1;
    cfg_idx  = 2'(idx);
    cfg_en   = en;
    cfg_prio = 3'(prio);
    cfg_edge = edg;
    tick();
    cfg_we   = 1'b0;
  endtask

  task automatic wait_req(input string name);
    int n;
    n = 0;
    while (!bus.irq_req_o && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (!bus.irq_req_o) begin
      errors++;
      $display("FAIL %s_timeout got req=0 required req=1 within 20 cycles", name);
    end
  endtask

  task automatic do_ack();
    bus.irq_ack_i = 1'b1;
    tick();
    bus.irq_ack_i = 1'b0;
  endtask

  task automatic do_done();
    bus.irq_done_i = 1'b1;
    tick();
    bus.irq_done_i = 1'b0;
  endtask

  // Monitor: each new request is matched against the oldest queued expectation.
  initial begin
    bit   prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev = 1'b0;
      end else begin
        if (bus.irq_req_o && !prev) begin
          checks++;
          if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_req got id=%0d prio=%0d required no request",
                     bus.irq_id_o, bus.irq_prio_o);
          end else begin
            e = q.pop_front();
            if (int'(bus.irq_id_o) != e.id || int'(bus.irq_prio_o) != e.prio) begin
              errors++;
              $display("FAIL req_id_prio got id=%0d prio=%0d required id=%0d prio=%0d",
                       bus.irq_id_o, bus.irq_prio_o, e.id, e.prio);
            end else begin
              $display("req id=%0d prio=%0d matched at %0t", e.id, e.prio, $time);
            end
          end
        end
        prev = bus.irq_req_o;
      end
    end
  end

  initial begin
    rst_n = 1'b0; irq = '0; cfg_we = 1'b0; cfg_idx = '0; cfg_en = 1'b0;
    cfg_prio = '0; cfg_edge = 1'b0; bus.irq_ack_i = 1'b0; bus.irq_done_i = 1'b0;
    repeat (3) tick();
    chk("rst_req", bus.irq_req_o, 0);
    chk("rst_id", bus.irq_id_o, 0);
    chk("rst_prio", bus.irq_prio_o, 0);
    chk("rst_level", level, 0);
    chk("rst_nest", nest, 0);
    rst_n = 1'b1;
    tick();

    // 1: highest priority wins, request one cycle after pending
    cfg(0, 1, 3, 0); cfg(1, 1, 0, 0); cfg(2, 1, 2, 0); cfg(3, 1, 1, 0);
    push(0, 3);
    irq = 4'b1111;
    tick();
    chk("t1_req_before", bus.irq_req_o, 0);
    tick();
    chk("t1_req_latency", bus.irq_req_o, 1);
    irq = '0;
    repeat (3) tick();
    chk("t1_req_dropped", bus.irq_req_o, 0);
    chk("t1_nest", nest, 0);

    // 2: tie goes to lowest index
    cfg(0, 1, 1, 0); cfg(1, 1, 3, 0); cfg(2, 1, 3, 0); cfg(3, 1, 0, 0);
    push(1, 3);
    irq = 4'b0110;
    wait_req("t2");
    do_ack();
    irq = '0;
    chk("t2_level", level, 3);
    chk("t2_nest", nest, 1);
    tick();
    do_done();
    chk("t2_pop_level", level, 0);
    chk("t2_pop_nest", nest, 0);

    // 3: preemption of a running level, then two returns
    cfg(0, 1, 1, 0); cfg(1, 1, 0, 0); cfg(2, 1, 2, 0); cfg(3, 1, 0, 0);
    push(0, 1);
    irq = 4'b0001;
    wait_req("t3a");
    do_ack();
    chk("t3_level1", level, 1);
    chk("t3_nest1", nest, 1);
    push(2, 2);
    irq = 4'b0101;
    wait_req("t3b");
    do_ack();
    chk("t3_level2", level, 2);
    chk("t3_nest2", nest, 2);
    irq = '0;
    tick();
    do_done();
    chk("t3_pop1_level", level, 1);
    chk("t3_pop1_nest", nest, 1);
    do_done();
    chk("t3_pop2_level", level, 0);
    chk("t3_pop2_nest", nest, 0);

    // 4: edge source, coalesced second pulse, single ack clears
    cfg(0, 1, 3, 1);
    push(0, 3);
    irq = 4'b0001; tick(); irq = '0;
    wait_req("t4a");
    irq = 4'b0001; tick(); irq = '0; tick();
    chk("t4_req_held", bus.irq_req_o, 1);
    do_ack();
    chk("t4_level", level, 3);
    chk("t4_nest", nest, 1);
    do_done();
    chk("t4_pop_level", level, 0);
    repeat (5) tick();
    chk("t4_pend_cleared", bus.irq_req_o, 0);
    push(0, 3);
    irq = 4'b0001; tick(); irq = '0;
    wait_req("t4b");
    do_ack();
    do_done();
    chk("t4_final_nest", nest, 0);

    // 5: level source drops while requesting
    cfg(3, 1, 2, 0);
    push(3, 2);
    irq = 4'b1000;
    wait_req("t5");
    irq = '0;
    tick();
    chk("t5_req_still", bus.irq_req_o, 1);
    tick();
    chk("t5_req_gone", bus.irq_req_o, 0);
    chk("t5_nest", nest, 0);
    chk("t5_level", level, 0);

    // 6: fill the nesting stack, blocked until a return, then reset mid-request
    cfg(0, 1, 1, 0); cfg(1, 1, 2, 0); cfg(2, 1, 3, 0); cfg(3, 1, 4, 0);
    for (int k = 0; k < 4; k++) begin
      push(k, k + 1);
      irq = irq | 4'(1 << k);
      wait_req("t6_nest");
      do_ack();
      chk("t6_level", level, k + 1);
      chk("t6_nest", nest, k + 1);
    end
    cfg(0, 1, 7, 0);
    repeat (4) tick();
    chk("t6_full_no_req", bus.irq_req_o, 0);
    push(0, 7);
    do_done();
    chk("t6_pop_level", level, 3);
    chk("t6_pop_nest", nest, 3);
    wait_req("t6_after_pop");
    rst_n = 1'b0;
    #1;
    chk("t6_rst_req", bus.irq_req_o, 0);
    chk("t6_rst_id", bus.irq_id_o, 0);
    chk("t6_rst_prio", bus.irq_prio_o, 0);
    chk("t6_rst_level", level, 0);
    chk("t6_rst_nest", nest, 0);
    irq = '0;
    tick();
    chk("queue_empty", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
